// File: rtl/axis2fifo_if.sv
// AXI4-Stream video input bundle for axis2fifo.
//   S_AXIS_TVALID / S_AXIS_TREADY : beat handshake
//   S_AXIS_TDATA                  : one pixel per beat
//   S_AXIS_TSTRB                  : byte strobes (carried, not interpreted by the sink)
//   S_AXIS_TLAST                  : last pixel of a line
//   S_AXIS_USER                   : first pixel of a frame (SOF)
interface axis2fifo_if #(
    parameter int unsigned AXIS_DATA_WIDTH = 32
) ();
    logic                         S_AXIS_TVALID;
    logic                         S_AXIS_TREADY;
    logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA;
    logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB;
    logic                         S_AXIS_TLAST;
    logic                         S_AXIS_USER;

    modport master (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_USER,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_USER,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/axis2fifo.sv
// Packs an AXI4-Stream pixel stream into 4-pixel FIFO words, tracking line/frame
// position, flagging sync errors and counting completed frames.
//   S_AXIS_ACLK    : clock, rising edge
//   S_AXIS_ARESETN : synchronous active-low reset
//   s_axis         : pixel stream input (slave side of axis2fifo_if)
//   fwr_en/fwr_dout/fwr_full : FIFO write port (lane 0 in the MSBs)
//   frame_done     : one-cycle pulse after the last beat of a frame is taken
//   frame_cnt      : completed-frame counter, wraps
//   sync_err       : sticky SOF/TLAST framing error
module axis2fifo #(
    parameter int unsigned FDW               = 128,
    parameter int unsigned AXIS_DATA_WIDTH   = 32,
    parameter int unsigned PIXELS_HORIZONTAL = 1280,
    parameter int unsigned PIXELS_VERTICAL   = 1024
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESETN,
    axis2fifo_if.slave        s_axis,
    output logic              fwr_en,
    output logic [FDW-1:0]    fwr_dout,
    input  logic              fwr_full,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              sync_err
);
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = (PIXELS_HORIZONTAL > 1) ? $clog2(PIXELS_HORIZONTAL) : 1;
    localparam int unsigned LW    = (PIXELS_VERTICAL > 1) ? $clog2(PIXELS_VERTICAL) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(PIXELS_HORIZONTAL - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(PIXELS_VERTICAL - 1);

    typedef enum logic {WAIT_SOF, ACTIVE} state_e;

    state_e          state_q, state_d;
    logic            hold_vld_q, hold_vld_d;
    logic [FDW-1:0]  hold_q, hold_d;
    logic [FDW-1:0]  acc_q, acc_d;
    logic            acc_done_q, acc_done_d;
    logic [1:0]      lane_q, lane_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   line_q, line_d;
    logic            frame_done_q, frame_done_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            sync_err_q, sync_err_d;

    logic            hold_free_c;
    logic            beat_c;
    logic            first_vld, second_vld;
    logic [FDW-1:0]  first_data, second_data, work;
    logic [1:0]      work_lane;
    logic            start, take, eol, col_last;
    logic [CW-1:0]   cur_col;
    logic [LW-1:0]   cur_line;
    logic            unused_tstrb_c;

    // Handshake and FIFO port
    assign hold_free_c          = !hold_vld_q || !fwr_full;
    assign s_axis.S_AXIS_TREADY = hold_free_c;
    assign beat_c               = s_axis.S_AXIS_TVALID && hold_free_c;
    assign fwr_en               = hold_vld_q && !fwr_full && S_AXIS_ARESETN;
    assign fwr_dout             = hold_q;
    assign frame_done           = frame_done_q;
    assign frame_cnt            = frame_cnt_q;
    assign sync_err             = sync_err_q;
    assign unused_tstrb_c       = ^s_axis.S_AXIS_TSTRB;

    // Next-state: frame tracking, lane packing and word hand-off
    always_comb begin
        state_d      = state_q;
        hold_vld_d   = hold_vld_q;
        hold_d       = hold_q;
        acc_d        = acc_q;
        acc_done_d   = acc_done_q;
        lane_d       = lane_q;
        col_d        = col_q;
        line_d       = line_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        sync_err_d   = sync_err_q;

        // A completed word parked in the accumulator is always the oldest pending word.
        first_vld   = acc_done_q;
        first_data  = acc_q;
        second_vld  = 1'b0;
        second_data = '0;
        work        = acc_done_q ? '0 : acc_q;
        work_lane   = lane_q;
        cur_col     = col_q;
        cur_line    = line_q;
        start       = 1'b0;
        take        = 1'b0;
        eol         = 1'b0;
        col_last    = 1'b0;

        if (beat_c) begin
            start = s_axis.S_AXIS_USER;
            take  = start || (state_q == ACTIVE);

            // SOF mid-frame: flush the partial word, then restart at pixel 0
            if (start && (state_q == ACTIVE) && ((col_q != '0) || (line_q != '0))) begin
                sync_err_d = 1'b1;
                if (lane_q != '0) begin
                    first_vld  = 1'b1;
                    first_data = acc_q;
                end
            end
            if (start) begin
                work      = '0;
                work_lane = '0;
                cur_col   = '0;
                cur_line  = '0;
            end

            if (take) begin
                for (int k = 0; k < int'(LANES); k++) begin
                    if (work_lane == 2'(k)) begin
                        work[FDW-1-AXIS_DATA_WIDTH*k -: AXIS_DATA_WIDTH] = s_axis.S_AXIS_TDATA;
                    end
                end
                col_last = (cur_col == COL_LAST);
                eol      = col_last || s_axis.S_AXIS_TLAST;
                if (s_axis.S_AXIS_TLAST != col_last) begin
                    sync_err_d = 1'b1;
                end
                if (eol || (work_lane == 2'(LANES - 1))) begin
                    second_vld  = 1'b1;
                    second_data = work;
                    work        = '0;
                    work_lane   = '0;
                end else begin
                    work_lane = work_lane + 2'd1;
                end

                state_d = ACTIVE;
                if (eol) begin
                    col_d = '0;
                    if (cur_line == LINE_LAST) begin
                        line_d       = '0;
                        state_d      = WAIT_SOF;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        line_d = cur_line + LW'(1);
                    end
                end else begin
                    col_d  = cur_col + CW'(1);
                    line_d = cur_line;
                end
            end
        end

        // Holding register takes the oldest word; a second word in the same cycle
        // (resync flush plus a completed resync beat) waits in the accumulator.
        if (hold_free_c) begin
            hold_vld_d = first_vld || second_vld;
            if (first_vld) begin
                hold_d = first_data;
            end else if (second_vld) begin
                hold_d = second_data;
            end
            if (first_vld && second_vld) begin
                acc_d      = second_data;
                acc_done_d = 1'b1;
                lane_d     = '0;
            end else begin
                acc_d      = work;
                acc_done_d = 1'b0;
                lane_d     = work_lane;
            end
        end
    end

    // State registers
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= WAIT_SOF;
            hold_vld_q   <= 1'b0;
            hold_q       <= '0;
            acc_q        <= '0;
            acc_done_q   <= 1'b0;
            lane_q       <= '0;
            col_q        <= '0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_vld_q   <= hold_vld_d;
            hold_q       <= hold_d;
            acc_q        <= acc_d;
            acc_done_q   <= acc_done_d;
            lane_q       <= lane_d;
            col_q        <= col_d;
            line_q       <= line_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            sync_err_q   <= sync_err_d;
        end
    end
endmodule
